// File: rtl/perceptron_predictor.sv
// perceptron_predictor: 2-stage perceptron branch predictor with a 3-state training FSM and speculative global history.
module perceptron_predictor #(
  parameter int HIST_LEN = 16,
  parameter int WEIGHT_W = 8,
  parameter int ENTRIES = 64,
  parameter int THETA = 44,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [31:0]             req_pc,
  output logic                    req_ready,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic signed [SUM_W-1:0] pred_sum,
  output logic [HIST_LEN-1:0]     pred_hist,
  input  logic                    upd_valid,
  input  logic [31:0]             upd_pc,
  input  logic                    upd_taken,
  input  logic signed [SUM_W-1:0] upd_sum,
  input  logic [HIST_LEN-1:0]     upd_hist,
  output logic                    upd_ready,
  output logic [HIST_LEN-1:0]     ghist
);
  localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_nx;
  logic signed [WEIGHT_W-1:0] tbl [ENTRIES][HIST_LEN+1];
  logic signed [WEIGHT_W-1:0] rd_w [HIST_LEN+1];
  logic signed [WEIGHT_W-1:0] nw [HIST_LEN+1];
  logic upd_acc, req_acc, mispredict, flush, train_now;
  logic [SUM_W-1:0] upd_mag;
  logic s1_valid, s2_valid, s2_taken;
  logic [INDEX_W-1:0] s1_idx, u_idx;
  logic [HIST_LEN-1:0] s1_hist, s2_hist, u_hist;
  logic signed [SUM_W-1:0] sum, s2_sum;
  logic u_taken, u_train;
  logic unused_bits;
  function automatic logic signed [WEIGHT_W-1:0] sat(input logic signed [WEIGHT_W-1:0] w, input logic up);
    return up ? (w == W_MAX ? w : w + WEIGHT_W'(1)) : (w == W_MIN ? w : w - WEIGHT_W'(1));
  endfunction
  // Reset forces IDLE-like handshakes so nothing is blocked while the FSM settles.
  assign upd_ready = rst || state == IDLE;
  assign req_ready = upd_ready && !upd_valid;
  assign upd_acc = upd_valid && upd_ready;
  assign req_acc = req_valid && req_ready;
  assign mispredict = !upd_sum[SUM_W-1] != upd_taken;
  assign flush = upd_acc && mispredict;
  assign upd_mag = upd_sum[SUM_W-1] ? -upd_sum : upd_sum;
  assign train_now = mispredict || upd_mag <= SUM_W'(THETA);
  assign pred_valid = s2_valid && !flush && !rst;
  assign pred_taken = s2_taken && !rst;
  assign pred_sum = rst ? '0 : s2_sum;
  assign pred_hist = rst ? '0 : s2_hist;
  assign unused_bits = ^{req_pc[31:INDEX_W+2], req_pc[1:0], upd_pc[31:INDEX_W+2], upd_pc[1:0]};
  always_comb begin
    sum = SUM_W'(tbl[s1_idx][0]);
    for (int i = 1; i <= HIST_LEN; i++)
      sum = s1_hist[i-1] ? sum + SUM_W'(tbl[s1_idx][i]) : sum - SUM_W'(tbl[s1_idx][i]);
  end
  always_comb begin
    nw[0] = sat(rd_w[0], u_taken);
    for (int i = 1; i <= HIST_LEN; i++)
      nw[i] = sat(rd_w[i], u_taken == u_hist[i-1]);
  end
  always_comb state_nx = state == IDLE ? (upd_acc ? READ : IDLE) : state == READ ? WRITE : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_taken <= 1'b0;
      s2_sum <= '0;
      s2_hist <= '0;
      ghist <= '0;
    end else begin
      state <= state_nx;
      s1_valid <= req_acc;
      s2_valid <= s1_valid && !flush;
      if (s1_valid) begin
        s2_sum <= sum;
        s2_taken <= !sum[SUM_W-1];
        s2_hist <= s1_hist;
      end
      ghist <= flush ? {upd_hist[HIST_LEN-2:0], upd_taken} : pred_valid ? {ghist[HIST_LEN-2:0], s2_taken} : ghist;
    end
  end
  always_ff @(posedge clk) begin
    if (req_acc) begin
      s1_idx <= req_pc[INDEX_W+1:2];
      s1_hist <= ghist;
    end
    if (upd_acc) begin
      u_idx <= upd_pc[INDEX_W+1:2];
      u_taken <= upd_taken;
      u_hist <= upd_hist;
      u_train <= train_now;
    end
    if (state == READ) rd_w <= tbl[u_idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < ENTRIES; e++)
        for (int i = 0; i <= HIST_LEN; i++)
          tbl[e][i] <= '0;
    end else if (state == WRITE && u_train) begin
      tbl[u_idx] <= nw;
    end
  end
endmodule

// File: tb/tb_perceptron_predictor.sv
// tb_perceptron_predictor: directed scoreboard bench for perceptron_predictor.
module tb_perceptron_predictor;
  localparam int HL = 16, SW = 14;
  logic clk = 1'b0, rst;
  logic req_valid, req_ready, pred_valid, pred_taken, upd_valid, upd_taken, upd_ready;
  logic [31:0] req_pc, upd_pc;
  logic signed [SW-1:0] pred_sum, upd_sum;
  logic [HL-1:0] pred_hist, upd_hist, ghist;
  typedef struct {logic signed [SW-1:0] s; logic t; logic [HL-1:0] h;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  perceptron_predictor #(.HIST_LEN(16), .WEIGHT_W(8), .ENTRIES(64), .THETA(44)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_sum(pred_sum), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_sum(upd_sum),
    .upd_hist(upd_hist), .upd_ready(upd_ready), .ghist(ghist)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pred_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pred: got pred_valid=1 sum=%0d, required no prediction", pred_sum);
      end else begin
        e = q.pop_front();
        chk("pred_sum", pred_sum, e.s);
        chk("pred_taken", pred_taken, e.t);
        chk("pred_hist", pred_hist, e.h);
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_req(input logic [31:0] pc, input logic out, input logic signed [SW-1:0] s, input logic t, input logic [HL-1:0] h);
    exp_t e;
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_pc = pc;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    chk("req_accept", acc, 1);
    req_valid = 1'b0;
    if (out) begin
      e.s = s; e.t = t; e.h = h;
      q.push_back(e);
    end
  endtask
  task automatic send_upd(input logic [31:0] pc, input logic tk, input logic signed [SW-1:0] s, input logic [HL-1:0] h);
    logic acc = 1'b0;
    upd_valid = 1'b1;
    upd_pc = pc; upd_taken = tk; upd_sum = s; upd_hist = h;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = upd_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("upd_accept", acc, 1);
    upd_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int cnt;
    rst = 1'b1; req_valid = 1'b0; req_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_sum = '0; upd_hist = '0;
    @(negedge clk);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_sum", pred_sum, 0);
    chk("rst_upd_ready", upd_ready, 1);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_ghist", ghist, 0);
    // zero weights give sum 0, which predicts taken
    send_req(32'h40, 1, 0, 1, 16'h0);
    idle(5);
    chk("ghist_after_pred", ghist, 16'h0001);
    send_upd(32'h40, 1, 0, 16'h0);
    idle(3);
    chk("ghist_correct_upd", ghist, 16'h0001);
    // mispredict on another entry restores ghist to 0
    send_upd(32'h80, 0, 0, 16'h0);
    chk("ghist_restore", ghist, 16'h0000);
    send_req(32'h40, 1, 17, 1, 16'h0);
    idle(5);
    repeat (199) send_upd(32'h40, 1, 0, 16'h0);
    send_upd(32'h80, 0, 0, 16'h0);
    send_req(32'h40, 1, 2175, 1, 16'h0);
    idle(5);
    chk("ghist_after_sat", ghist, 16'h0001);
    send_upd(32'h40, 1, 50, 16'h0);
    idle(3);
    chk("ghist_no_train", ghist, 16'h0001);
    send_req(32'h40, 1, 1919, 1, 16'h0001);
    idle(5);
    chk("ghist_hist1", ghist, 16'h0003);
    send_req(32'h40, 0, 0, 0, 16'h0);
    send_req(32'h44, 0, 0, 0, 16'h0);
    send_upd(32'h80, 1, -5, 16'h00F0);
    chk("ghist_mispredict", ghist, 16'h01E1);
    idle(6);
    chk("ghist_after_flush", ghist, 16'h01E1);
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_sum = 50; upd_hist = '0;
    req_valid = 1'b1; req_pc = 32'h40;
    @(negedge clk);
    chk("contend_upd_ready", upd_ready, 1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    cnt = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
      @(posedge clk); #1;
    end
    chk("req_ready_low_cycles", cnt, 3);
    begin
      exp_t e;
      e.s = 895; e.t = 1'b1; e.h = 16'h01E1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    idle(5);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    send_upd(32'h40, 0, 0, 16'h0);
    send_req(32'h40, 1, -17, 0, 16'h0);
    idle(6);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
